// File: rtl/reservation_station.sv
// In-order reservation station: circular FIFO of renamed ops feeding
// the scoreboard read port and a one-deep execute output register.
module reservation_station #(
    parameter int NUM_ENTRY  = 4,
    parameter int NUM_REG    = 8,
    parameter int OP_BIT     = 4,
    parameter int REG_ID_BIT = $clog2(NUM_REG),
    parameter int CNT_BIT    = $clog2(NUM_ENTRY + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_vld,
    output logic                  issue_rdy,
    input  logic [OP_BIT-1:0]     issue_op,
    input  logic [REG_ID_BIT-1:0] issue_dst_reg,
    input  logic [REG_ID_BIT-1:0] issue_src_reg0,
    input  logic [REG_ID_BIT-1:0] issue_src_reg1,
    output logic                  fu_available,
    output logic [NUM_REG-1:0]    reg_read_pending,
    output logic                  rd_vld,
    input  logic                  rd_rdy,
    output logic [REG_ID_BIT-1:0] rd_reg0_id,
    output logic [REG_ID_BIT-1:0] rd_reg1_id,
    output logic [REG_ID_BIT-1:0] rd_write_reg_id_nxt,
    output logic                  ex_vld,
    input  logic                  ex_rdy,
    output logic [OP_BIT-1:0]     ex_op,
    output logic [REG_ID_BIT-1:0] ex_dst_reg
);

    localparam int PTR_BIT = $clog2(NUM_ENTRY);
    localparam logic [PTR_BIT-1:0] LAST = PTR_BIT'(NUM_ENTRY - 1);
    localparam logic [CNT_BIT-1:0] FULL = CNT_BIT'(NUM_ENTRY);

    logic [OP_BIT-1:0]     op_q   [NUM_ENTRY];
    logic [REG_ID_BIT-1:0] dst_q  [NUM_ENTRY];
    logic [REG_ID_BIT-1:0] src0_q [NUM_ENTRY];
    logic [REG_ID_BIT-1:0] src1_q [NUM_ENTRY];
    logic [NUM_ENTRY-1:0]  vld_q;

    logic [PTR_BIT-1:0] head;
    logic [PTR_BIT-1:0] tail;
    logic [CNT_BIT-1:0] count;

    logic has_entry;
    logic ex_free;
    logic push;
    logic pop;

    assign has_entry    = (count != '0);
    assign issue_rdy    = (count != FULL);
    assign fu_available = issue_rdy;
    assign ex_free      = !ex_vld || ex_rdy;
    assign rd_vld       = has_entry && ex_free;
    assign push         = issue_vld && issue_rdy;
    assign pop          = rd_vld && rd_rdy;

    assign rd_reg0_id          = has_entry ? src0_q[head] : '0;
    assign rd_reg1_id          = has_entry ? src1_q[head] : '0;
    assign rd_write_reg_id_nxt = has_entry ? dst_q[head]  : '0;

    // Register 0 means "unused", so it never shows as pending.
    always_comb begin
        reg_read_pending = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (vld_q[i]) begin
                reg_read_pending[src0_q[i]] = 1'b1;
                reg_read_pending[src1_q[i]] = 1'b1;
            end
        end
        reg_read_pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < NUM_ENTRY; i++) begin
                op_q[i]   <= '0;
                dst_q[i]  <= '0;
                src0_q[i] <= '0;
                src1_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                vld_q[head] <= 1'b0;
            end
            if (push) begin
                vld_q[tail]  <= 1'b1;
                op_q[tail]   <= issue_op;
                dst_q[tail]  <= issue_dst_reg;
                src0_q[tail] <= issue_src_reg0;
                src1_q[tail] <= issue_src_reg1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == LAST) ? '0 : head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A pop in the same cycle the FU consumes reloads without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld     <= 1'b0;
            ex_op      <= '0;
            ex_dst_reg <= '0;
        end else if (pop) begin
            ex_vld     <= 1'b1;
            ex_op      <= op_q[head];
            ex_dst_reg <= dst_q[head];
        end else if (ex_vld && ex_rdy) begin
            ex_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with hand-computed expectations.
module tb_reservation_station;

    logic       clk;
    logic       rst_n;
    logic       issue_vld;
    logic       issue_rdy;
    logic [3:0] issue_op;
    logic [2:0] issue_dst_reg;
    logic [2:0] issue_src_reg0;
    logic [2:0] issue_src_reg1;
    logic       fu_available;
    logic [7:0] reg_read_pending;
    logic       rd_vld;
    logic       rd_rdy;
    logic [2:0] rd_reg0_id;
    logic [2:0] rd_reg1_id;
    logic [2:0] rd_write_reg_id_nxt;
    logic       ex_vld;
    logic       ex_rdy;
    logic [3:0] ex_op;
    logic [2:0] ex_dst_reg;

    int checks = 0;
    int errors = 0;

    reservation_station dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .issue_vld           (issue_vld),
        .issue_rdy           (issue_rdy),
        .issue_op            (issue_op),
        .issue_dst_reg       (issue_dst_reg),
        .issue_src_reg0      (issue_src_reg0),
        .issue_src_reg1      (issue_src_reg1),
        .fu_available        (fu_available),
        .reg_read_pending    (reg_read_pending),
        .rd_vld              (rd_vld),
        .rd_rdy              (rd_rdy),
        .rd_reg0_id          (rd_reg0_id),
        .rd_reg1_id          (rd_reg1_id),
        .rd_write_reg_id_nxt (rd_write_reg_id_nxt),
        .ex_vld              (ex_vld),
        .ex_rdy              (ex_rdy),
        .ex_op               (ex_op),
        .ex_dst_reg          (ex_dst_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [3:0] op,
                             input logic [2:0] d, input logic [2:0] s0,
                             input logic [2:0] s1);
        issue_vld      = v;
        issue_op       = op;
        issue_dst_reg  = d;
        issue_src_reg0 = s0;
        issue_src_reg1 = s1;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_rdy = 1'b0;
        ex_rdy = 1'b0;
        set_issue(1'b0, 4'd0, 3'd0, 3'd0, 3'd0);
        #1;
        chk("rst_issue_rdy", 32'(issue_rdy), 1);
        chk("rst_fu_avail", 32'(fu_available), 1);
        chk("rst_rd_vld", 32'(rd_vld), 0);
        chk("rst_ex_vld", 32'(ex_vld), 0);
        chk("rst_pending", 32'(reg_read_pending), 32'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_issue_rdy", 32'(issue_rdy), 1);
        chk("idle_rd_vld", 32'(rd_vld), 0);

        // Single op through both stages
        rd_rdy = 1'b1;
        ex_rdy = 1'b1;
        set_issue(1'b1, 4'd3, 3'd5, 3'd2, 3'd4);
        chk("push_cyc_pending", 32'(reg_read_pending), 32'h00);
        tick();
        issue_vld = 1'b0;
        chk("p1_pending", 32'(reg_read_pending), 32'h14);
        chk("p1_rd_vld", 32'(rd_vld), 1);
        chk("p1_rd0", 32'(rd_reg0_id), 2);
        chk("p1_rd1", 32'(rd_reg1_id), 4);
        chk("p1_rdw", 32'(rd_write_reg_id_nxt), 5);
        tick();
        chk("p2_ex_vld", 32'(ex_vld), 1);
        chk("p2_ex_op", 32'(ex_op), 3);
        chk("p2_ex_dst", 32'(ex_dst_reg), 5);
        chk("p2_pending", 32'(reg_read_pending), 32'h00);
        chk("p2_rd_vld", 32'(rd_vld), 0);
        chk("p2_rd0_empty", 32'(rd_reg0_id), 0);
        tick();
        chk("p3_ex_vld", 32'(ex_vld), 0);
        chk("p3_ex_op_hold", 32'(ex_op), 3);

        // Fill with head blocked; tail wraps 3->0
        rd_rdy = 1'b0;
        set_issue(1'b1, 4'd1, 3'd1, 3'd1, 3'd2);
        tick();
        set_issue(1'b1, 4'd2, 3'd2, 3'd3, 3'd0);
        tick();
        chk("fill2_issue_rdy", 32'(issue_rdy), 1);
        set_issue(1'b1, 4'd4, 3'd3, 3'd5, 3'd5);
        tick();
        set_issue(1'b1, 4'd5, 3'd4, 3'd6, 3'd7);
        tick();
        chk("full_issue_rdy", 32'(issue_rdy), 0);
        chk("full_fu_avail", 32'(fu_available), 0);
        chk("full_pending", 32'(reg_read_pending), 32'hEE);
        chk("full_rd_vld", 32'(rd_vld), 1);
        chk("full_head_rd0", 32'(rd_reg0_id), 1);
        chk("full_head_rd1", 32'(rd_reg1_id), 2);

        // Fifth op offered while full and popping: refused this cycle
        set_issue(1'b1, 4'd6, 3'd6, 3'd0, 3'd0);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        chk("pp_issue_rdy", 32'(issue_rdy), 1);
        chk("pp_ex_op", 32'(ex_op), 1);
        chk("pp_ex_dst", 32'(ex_dst_reg), 1);
        chk("pp_pending", 32'(reg_read_pending), 32'hE8);
        chk("pp_head_rd0", 32'(rd_reg0_id), 3);
        chk("pp_head_rdw", 32'(rd_write_reg_id_nxt), 2);
        tick();
        issue_vld = 1'b0;
        chk("pp2_issue_rdy", 32'(issue_rdy), 0);
        chk("pp2_ex_vld", 32'(ex_vld), 0);
        chk("pp2_ex_op_hold", 32'(ex_op), 1);
        chk("pp2_pending", 32'(reg_read_pending), 32'hE8);

        // Execute stall holds the head
        ex_rdy = 1'b0;
        rd_rdy = 1'b1;
        tick();
        chk("st_ex_vld", 32'(ex_vld), 1);
        chk("st_ex_op", 32'(ex_op), 2);
        chk("st_rd_vld", 32'(rd_vld), 0);
        chk("st_head_rd0", 32'(rd_reg0_id), 5);
        tick();
        chk("st2_ex_op", 32'(ex_op), 2);
        chk("st2_rd_vld", 32'(rd_vld), 0);
        chk("st2_pending", 32'(reg_read_pending), 32'hE0);
        chk("st2_issue_rdy", 32'(issue_rdy), 1);

        // Back-to-back drain, one op per cycle in push order
        ex_rdy = 1'b1;
        #1;
        chk("dr_rd_vld", 32'(rd_vld), 1);
        tick();
        chk("dr1_ex_vld", 32'(ex_vld), 1);
        chk("dr1_ex_op", 32'(ex_op), 4);
        tick();
        chk("dr2_ex_vld", 32'(ex_vld), 1);
        chk("dr2_ex_op", 32'(ex_op), 5);
        chk("dr2_ex_dst", 32'(ex_dst_reg), 4);
        tick();
        chk("dr3_ex_vld", 32'(ex_vld), 1);
        chk("dr3_ex_op", 32'(ex_op), 6);
        chk("dr3_ex_dst", 32'(ex_dst_reg), 6);
        chk("dr3_rd_vld", 32'(rd_vld), 0);
        chk("dr3_pending", 32'(reg_read_pending), 32'h00);
        tick();
        chk("dr4_ex_vld", 32'(ex_vld), 0);

        // Async reset with entries queued and ex occupied
        rd_rdy = 1'b0;
        set_issue(1'b1, 4'd7, 3'd1, 3'd2, 3'd3);
        tick();
        set_issue(1'b1, 4'd8, 3'd2, 3'd2, 3'd0);
        tick();
        set_issue(1'b1, 4'd9, 3'd3, 3'd4, 3'd0);
        tick();
        issue_vld = 1'b0;
        chk("ar_pending3", 32'(reg_read_pending), 32'h1C);
        rd_rdy = 1'b1;
        ex_rdy = 1'b0;
        tick();
        chk("ar_ex_vld", 32'(ex_vld), 1);
        chk("ar_ex_op", 32'(ex_op), 7);
        chk("ar_pending2", 32'(reg_read_pending), 32'h14);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rst_ex_vld", 32'(ex_vld), 0);
        chk("ar_rst_ex_op", 32'(ex_op), 0);
        chk("ar_rst_ex_dst", 32'(ex_dst_reg), 0);
        chk("ar_rst_rd_vld", 32'(rd_vld), 0);
        chk("ar_rst_pending", 32'(reg_read_pending), 32'h00);
        chk("ar_rst_issue_rdy", 32'(issue_rdy), 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_rd_vld", 32'(rd_vld), 0);
        chk("post_rst_ex_vld", 32'(ex_vld), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Per-FU in-order reservation station between the scoreboard issue stage and the FU's operand-read / execute stage.
- Accepts renamed instructions from issue and buffers up to NUM_ENTRY of them in a circular FIFO.
- Presents the oldest entry's register-read request to the scoreboard read port and moves accepted entries into a one-deep execute output register.
- Reports occupancy (fu_available) and a bitmap of source registers still awaiting read (reg_read_pending) back to the scoreboard.

Parameters:
NUM_ENTRY, 4, FIFO depth; any value >=2, not required to be a power of 2
NUM_REG, 8, physical register count
OP_BIT, 4, opcode width
REG_ID_BIT, $clog2(NUM_REG), register id width
CNT_BIT, $clog2(NUM_ENTRY+1), occupancy counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
issue_vld  in  1  issue request for this FU
issue_rdy  out  1  entry free (count != NUM_ENTRY)
issue_op  in  OP_BIT  opcode
issue_dst_reg  in  REG_ID_BIT  renamed dst; 0 = no result
issue_src_reg0  in  REG_ID_BIT  renamed src0; 0 = unused
issue_src_reg1  in  REG_ID_BIT  renamed src1; 0 = unused
fu_available  out  1  equals issue_rdy
reg_read_pending  out  NUM_REG  OR of src0/src1 decodes over valid FIFO entries; bit 0 always 0
rd_vld  out  1  read request for the head entry
rd_rdy  in  1  scoreboard accepts the read
rd_reg0_id  out  REG_ID_BIT  head src0
rd_reg1_id  out  REG_ID_BIT  head src1
rd_write_reg_id_nxt  out  REG_ID_BIT  head dst
ex_vld  out  1  execute stage holds an op
ex_rdy  in  1  FU consumes the op
ex_op  out  OP_BIT  latched opcode
ex_dst_reg  out  REG_ID_BIT  latched dst

Behaviour:
- Reset (async, rst_n=0): head=0, tail=0, count=0, all entry valid bits 0, ex_vld=0, ex_op=0, ex_dst_reg=0.
  - Consequences: issue_rdy=1, fu_available=1, rd_vld=0, reg_read_pending=0.
  - Reset mid-operation discards all entries and the ex stage.
- Push: when issue_vld && issue_rdy, write {op,dst,src0,src1} at tail; tail <= (tail==NUM_ENTRY-1)?0:tail+1.
- issue_rdy depends only on registered count; it is not raised by a same-cycle pop. When full, a push is refused even if a pop occurs that cycle.
- ex_free = !ex_vld || ex_rdy.
- rd_vld = (count!=0) && ex_free. rd_* ids are the head entry fields, combinational from state; they are 0 when count==0.
- Pop: when rd_vld && rd_rdy, head advances with the same wrap rule.
  - ex_vld <= 1; ex_op and ex_dst_reg are loaded from the head entry.
  - Latency: entry pushed in cycle N can be popped in cycle N+1 at the earliest; it appears on ex_* in cycle N+2.
- Else if ex_vld && ex_rdy: ex_vld <= 0; ex_op and ex_dst_reg hold.
- Simultaneous push and pop: count unchanged; head and tail both advance.
- Simultaneous pop and ex consume: ex register reloads, ex_vld stays 1. This gives 1 op/cycle throughput.
- count <= count + push - pop; it never exceeds NUM_ENTRY and never underflows.
- reg_read_pending: registered state only; the entry being pushed this cycle does not contribute. Bits clear in the cycle after pop. A reg used as both src0 and src1, or in several entries, stays set until all those entries are popped.
- No reordering: the FIFO is strictly in order. A blocked head (rd_rdy=0) stalls younger entries.
- rd_vld must not depend on rd_rdy. issue_rdy must not depend on issue_vld.

Test Plan:
- Reset then idle → issue_rdy=1, rd_vld=0, ex_vld=0, reg_read_pending=8'h00.
- Push op=3, dst=5, src0=2, src1=4 with rd_rdy=1, ex_rdy=1:
  - cycle+1: reg_read_pending=8'h14, rd_vld=1, rd_reg0_id=2, rd_reg1_id=4, rd_write_reg_id_nxt=5.
  - cycle+2: ex_vld=1, ex_op=3, ex_dst_reg=5, reg_read_pending=0.
- rd_rdy=0, push 4 ops → issue_rdy=0 after the 4th push; a 5th issue_vld is not accepted. Raise rd_rdy → pops in push order, with tail/head wrap 3→0 confirmed by a further push/pop.
- Full FIFO, issue_vld=1 and pop in the same cycle → push refused that cycle, count=3. Next cycle push accepted, count=4.
- ex_rdy=0 with ex_vld=1 → rd_vld=0, entries held. Toggle ex_rdy=1 continuously → one ex op per cycle, no bubbles.
- Assert rst_n=0 with 2 entries and ex_vld=1 → all outputs return to reset values immediately, without waiting for a clock edge.
